modexp_ctrl: RTL
================

MODEXP_CTRL -- requirements
Module: modexp_ctrl

Interface
REQ-001 SHALL have parameter EXPW, default 64, exponent width in bits (1..64).
REQ-002 SHALL have parameter TMO, default 4096, the per-request response timeout in cycles, used only with MODEXP_ERRCHK_EN.
REQ-003 SHALL have the following ports, one per line as name, direction, width, meaning; clock and reset first:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job request, accepted only when ready=1.
- base  in  64  base operand, any value.
- exponent  in  EXPW  exponent.
- job_id  in  32  caller tag, returned with the result.
- ready  out  1  idle, can accept a job.
- done  out  1  one-cycle result strobe.
- done_id  out  32  job_id of the finished job.
- value  out  64  base^exponent mod PR.
- err  out  1  sticky error flag.
- mstart  out  1  multiply request to the mod-multiplier server.
- maa  out  64  first multiplicand.
- mbb  out  64  second multiplicand.
- mid  out  32  request tag.
- mvld  in  1  server result valid.
- mresult  in  64  server result (aa*bb mod PR).
- mid_ret  in  32  tag returned in order with mresult.
- mbusy  in  1  server holds outstanding work.

Function
REQ-004 SHALL compute value = base^exponent mod PR, PR = 17640718939615885909, using right-to-left square-and-multiply; the server performs all multiplications.
REQ-005 SHALL implement FSM states IDLE, REDUCE, WAIT_R, ISSUE, WAIT, DONE.
REQ-006 IDLE: ready=1; start=1 latches base, exponent and job_id, then goes to DONE with value=1 if exponent==0, else to REDUCE.
REQ-007 REDUCE: issues one request maa=base, mbb=1, mid={tag step,2'b10}, then goes to WAIT_R; the result becomes b (reduced base) and acc=1.
REQ-008 ISSUE, per exponent LSB: if bit=1, issues acc*b with mid[1:0]=2'b01; if the remaining shifted exponent is nonzero, issues b*b with mid[1:0]=2'b00; at most one mstart per cycle, multiply first, square on the next cycle; the state then goes to WAIT.
REQ-009 mid[31:2] SHALL carry a 30-bit step counter that resets to 0 per job and increments per ISSUE.
REQ-010 WAIT: each mvld routes mresult by mid_ret[1:0] (01 to acc, 00 to b); once all requests issued in the step have returned, the exponent shifts right by 1; the state goes to DONE if it is now zero, else back to ISSUE.
REQ-011 DONE: one-cycle done=1 with value=acc and done_id=job_id, then IDLE; value and done_id hold until the next done.
REQ-012 Outstanding requests SHALL never exceed 2, and start SHALL be ignored when ready=0.
REQ-013 mvld in REDUCE, ISSUE or IDLE is unexpected: it SHALL be ignored, and err SHALL be set under MODEXP_ERRCHK_EN.
REQ-014 The request count for exponent E SHALL be 1 + popcount(E) + (msb_index(E)).

Reset
REQ-015 On rst_n=0, asynchronously: FSM=IDLE, ready=1, done=0, mstart=0, err=0, and value, done_id, maa, mbb and mid all 0.
REQ-016 Reset mid-job SHALL abandon the job without producing done; results still in flight in the server after reset SHALL be discarded under REQ-013.

Configuration
REQ-017 With MODEXP_ERRCHK_EN defined: err SHALL be set sticky when mid_ret differs from the expected in-order tag, on an unexpected mvld, or when a WAIT/WAIT_R lasts TMO cycles; a timeout SHALL return the FSM to IDLE without done.
REQ-018 Without MODEXP_ERRCHK_EN: err SHALL be tied to 0, tags SHALL be decoded by mid_ret[1:0] only, and no timeout counter SHALL exist.

Structure
REQ-019 A shared package SHALL hold: PR constant, tag codes (SQ=2'b00, MUL=2'b01, RED=2'b10), and the FSM state enum.
REQ-020 A single sub-module, modexp_tagq (2-entry expected-tag FIFO), SHALL be instantiated only under MODEXP_ERRCHK_EN.

Verification
REQ-021 The bench SHALL cover the following scenarios, each against a behavioural mod-multiplier server with random latency of 5-40 cycles:
- base=3, exp=0, job_id=7 -> done within 2 cycles, value=1, done_id=7, no mstart.
- base=3, exp=5 -> value=243, exactly 5 mstart pulses.
- base=2, exp=64 (EXPW=64) -> value=806025134093665707.
- base=PR+5, exp=2 -> value=25 (reduction path).
- Server returns a corrupted mid_ret, with MODEXP_ERRCHK_EN -> err=1, held until reset.
- rst_n pulsed mid-WAIT, then a new job base=3, exp=5 -> the stale mvld is ignored, value=243 and done fires once.

Source files
------------

// File: rtl/modexp_ctrl_pkg.sv
// Shared definitions for the modular-exponentiation controller: modulus, request tag codes, FSM states.
package modexp_ctrl_pkg;

  localparam logic [63:0] PR = 64'd17640718939615885909;

  localparam logic [1:0] TAG_SQ  = 2'b00;
  localparam logic [1:0] TAG_MUL = 2'b01;
  localparam logic [1:0] TAG_RED = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REDUCE = 3'd1,
    WAIT_R = 3'd2,
    ISSUE  = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/modexp_tagq.sv
// Two-entry FIFO of request tags still expected back from the mod-multiplier, oldest at the front.
module modexp_tagq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        push,
  input  logic [31:0] push_tag,
  input  logic        pop,
  output logic        valid,
  output logic [31:0] front
);

  logic [31:0] mem0_q, mem0_d, mem1_q, mem1_d;
  logic        rd_q, rd_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        do_pop, do_push, wr_sel;

  assign valid = (cnt_q != 2'd0);
  assign front = rd_q ? mem1_q : mem0_q;

  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    do_pop  = pop && (cnt_q != 2'd0);
    do_push = push && ((cnt_q != 2'd2) || do_pop);
    wr_sel  = rd_q ^ cnt_q[0];
    if (flush) begin
      rd_d  = 1'b0;
      cnt_d = 2'd0;
    end else begin
      if (do_push) begin
        if (wr_sel) mem1_d = push_tag;
        else        mem0_d = push_tag;
      end
      if (do_pop) rd_d = ~rd_q;
      cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0_q <= '0;
      mem1_q <= '0;
      rd_q   <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/modexp_ctrl.sv
// Right-to-left square-and-multiply sequencer; all products come from an external mod-multiplier.
// Define MODEXP_ERRCHK_EN for tag checking, unexpected-response detection and a wait timeout.
// IDLE: accept job | REDUCE: send base*1 | WAIT_R: await reduced base
// ISSUE: send acc*b and/or b*b | WAIT: collect step results | DONE: result strobe
module modexp_ctrl
  import modexp_ctrl_pkg::*;
#(
  parameter int EXPW = 64,
  parameter int TMO  = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [63:0]     base,
  input  logic [EXPW-1:0] exponent,
  input  logic [31:0]     job_id,
  output logic            ready,
  output logic            done,
  output logic [31:0]     done_id,
  output logic [63:0]     value,
  output logic            err,
  output logic            mstart,
  output logic [63:0]     maa,
  output logic [63:0]     mbb,
  output logic [31:0]     mid,
  input  logic            mvld,
  input  logic [63:0]     mresult,
  input  logic [31:0]     mid_ret,
  input  logic            mbusy
);

  state_t          state_q, state_d;
  logic [63:0]     base_q, base_d, b_q, b_d, acc_q, acc_d;
  logic [63:0]     value_q, value_d, maa_q, maa_d, mbb_q, mbb_d;
  logic [EXPW-1:0] exp_q, exp_d, exp_sh;
  logic [31:0]     id_q, id_d, done_id_q, done_id_d, mid_q, mid_d;
  logic [29:0]     step_q, step_d;
  logic [1:0]      pend_q, pend_d;
  logic            mul_done_q, mul_done_d, ready_q, ready_d;
  logic            done_q, done_d, mstart_q, mstart_d;
  logic            in_wait, mul_now;

  assign exp_sh  = exp_q >> 1;
  assign in_wait = (state_q == WAIT_R) || (state_q == WAIT);
  assign mul_now = exp_q[0] && !mul_done_q;

  assign ready   = ready_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign value   = value_q;
  assign mstart  = mstart_q;
  assign maa     = maa_q;
  assign mbb     = mbb_q;
  assign mid     = mid_q;

`ifdef MODEXP_ERRCHK_EN
  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          tq_valid;
  logic [31:0]   tq_front;
  logic          unused_ok;

  assign err       = err_q;
  assign unused_ok = mbusy;

  modexp_tagq u_tagq (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    ((state_q == IDLE) && start),
    .push     (mstart_d),
    .push_tag (mid_d),
    .pop      (mvld && in_wait && tq_valid),
    .valid    (tq_valid),
    .front    (tq_front)
  );
`else
  logic unused_ok;

  assign err       = 1'b0;
  assign unused_ok = ^{mbusy, mid_ret[31:2]};
`endif

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    b_d        = b_q;
    acc_d      = acc_q;
    exp_d      = exp_q;
    id_d       = id_q;
    step_d     = step_q;
    pend_d     = pend_q;
    mul_done_d = mul_done_q;
    value_d    = value_q;
    done_id_d  = done_id_q;
    maa_d      = maa_q;
    mbb_d      = mbb_q;
    mid_d      = mid_q;
    mstart_d   = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d     = base;
          exp_d      = exponent;
          id_d       = job_id;
          step_d     = '0;
          pend_d     = 2'd0;
          mul_done_d = 1'b0;
          if (exponent == '0) begin
            acc_d     = 64'd1;
            state_d   = DONE;
            done_d    = 1'b1;
            value_d   = 64'd1;
            done_id_d = job_id;
          end else begin
            state_d = REDUCE;
          end
        end
      end
      REDUCE: begin
        mstart_d = 1'b1;
        maa_d    = base_q;
        mbb_d    = 64'd1;
        mid_d    = {step_q, TAG_RED};
        pend_d   = 2'd1;
        state_d  = WAIT_R;
      end
      WAIT_R: begin
        if (mvld && (mid_ret[1:0] == TAG_RED)) begin
          b_d     = mresult;
          acc_d   = 64'd1;
          pend_d  = 2'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Multiply goes out first; a needed square follows on the next cycle.
        mstart_d = 1'b1;
        pend_d   = pend_q + 2'd1;
        if (mul_now) begin
          maa_d      = acc_q;
          mbb_d      = b_q;
          mid_d      = {step_q, TAG_MUL};
          mul_done_d = 1'b1;
        end else begin
          maa_d = b_q;
          mbb_d = b_q;
          mid_d = {step_q, TAG_SQ};
        end
        if (!mul_now || (exp_sh == '0)) begin
          state_d    = WAIT;
          step_d     = step_q + 30'd1;
          mul_done_d = 1'b0;
        end
      end
      WAIT: begin
        if (mvld && ((mid_ret[1:0] == TAG_MUL) || (mid_ret[1:0] == TAG_SQ))) begin
          if (mid_ret[1:0] == TAG_MUL) acc_d = mresult;
          else                         b_d   = mresult;
          pend_d = pend_q - 2'd1;
          if (pend_q == 2'd1) begin
            exp_d = exp_sh;
            if (exp_sh == '0) begin
              state_d   = DONE;
              done_d    = 1'b1;
              value_d   = acc_d;
              done_id_d = id_q;
            end else begin
              state_d = ISSUE;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef MODEXP_ERRCHK_EN
    err_d = err_q;
    tmo_d = TW'(TMO - 1);
    if (mvld && (!in_wait || !tq_valid || (mid_ret != tq_front))) err_d = 1'b1;
    if (in_wait) begin
      if (tmo_q == '0) begin
        err_d     = 1'b1;
        state_d   = IDLE;
        pend_d    = 2'd0;
        done_d    = 1'b0;
        value_d   = value_q;
        done_id_d = done_id_q;
      end else begin
        tmo_d = tmo_q - 1'b1;
      end
    end
`endif

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      exp_q      <= '0;
      id_q       <= '0;
      step_q     <= '0;
      pend_q     <= 2'd0;
      mul_done_q <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      value_q    <= '0;
      done_id_q  <= '0;
      mstart_q   <= 1'b0;
      maa_q      <= '0;
      mbb_q      <= '0;
      mid_q      <= '0;
`ifdef MODEXP_ERRCHK_EN
      err_q      <= 1'b0;
      tmo_q      <= TW'(TMO - 1);
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      exp_q      <= exp_d;
      id_q       <= id_d;
      step_q     <= step_d;
      pend_q     <= pend_d;
      mul_done_q <= mul_done_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      value_q    <= value_d;
      done_id_q  <= done_id_d;
      mstart_q   <= mstart_d;
      maa_q      <= maa_d;
      mbb_q      <= mbb_d;
      mid_q      <= mid_d;
`ifdef MODEXP_ERRCHK_EN
      err_q      <= err_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

endmodule
